// File: rtl/evt2_stream_decoder.sv
// EVT 2.0 word decoder: CD/TIME_HIGH decode, grid scaling, range/polarity filtering,
// 2-entry output FIFO with ready/valid handshake and saturating statistics.
module evt2_stream_decoder #(
  parameter int GRID_BITS = 4,
  parameter int SENSOR_W  = 320,
  parameter int SENSOR_H  = 320,
  parameter int TS_BITS   = 24,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           pol_mask,
  output logic [GRID_BITS-1:0] out_x,
  output logic [GRID_BITS-1:0] out_y,
  output logic                 out_pol,
  output logic [TS_BITS-1:0]   out_ts,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_BITS-1:0]  evt_count,
  output logic [CNT_BITS-1:0]  drop_count,
  output logic                 ts_seen
);

  localparam int GRID_N = 1 << GRID_BITS;
  localparam int ENTRY_W = 2 * GRID_BITS + 1 + TS_BITS;

  // Fixed-point reciprocal scales (16 fractional bits), rounded up so the last
  // in-range pixel still lands in the last grid cell.
  localparam logic [63:0] XSCALE_W = ((64'(GRID_N) << 16) + 64'(SENSOR_W) - 64'd1) / 64'(SENSOR_W);
  localparam logic [63:0] YSCALE_W = ((64'(GRID_N) << 16) + 64'(SENSOR_H) - 64'd1) / 64'(SENSOR_H);
  localparam logic [31:0] XSCALE = XSCALE_W[31:0];
  localparam logic [31:0] YSCALE = YSCALE_W[31:0];

  logic [3:0]           word_type;
  logic                 accept;
  logic                 is_cd;
  logic                 is_th;
  logic                 pol;
  logic [5:0]           ts_lsb;
  logic [10:0]          x_raw;
  logic [10:0]          y_raw;
  logic                 range_ok;
  logic                 mask_ok;
  logic                 push;
  logic                 drop;
  logic                 pop;
  logic [42:0]          x_prod;
  logic [42:0]          y_prod;
  logic [GRID_BITS-1:0] grid_x;
  logic [GRID_BITS-1:0] grid_y;
  logic [33:0]          ts_full;
  logic [TS_BITS-1:0]   ts_trunc;
  logic [ENTRY_W-1:0]   entry;

  logic [27:0]          time_high_reg;
  logic [ENTRY_W-1:0]   fifo_mem [2];
  logic                 wr_ptr_reg;
  logic                 rd_ptr_reg;
  logic [1:0]           count_reg;

  assign word_type = in_data[31:28];
  assign ts_lsb    = in_data[27:22];
  assign x_raw     = in_data[21:11];
  assign y_raw     = in_data[10:0];
  assign pol       = in_data[28];

  assign in_ready  = (count_reg < 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign is_cd = (word_type[3:1] == 3'b000);
  assign is_th = (word_type == 4'h8);

  assign range_ok = ({21'd0, x_raw} < 32'(SENSOR_W)) && ({21'd0, y_raw} < 32'(SENSOR_H));
  assign mask_ok  = pol_mask[pol];
  assign push     = accept && is_cd && range_ok && mask_ok;
  assign drop     = accept && is_cd && !(range_ok && mask_ok);

  assign x_prod = {32'd0, x_raw} * {11'd0, XSCALE};
  assign y_prod = {32'd0, y_raw} * {11'd0, YSCALE};
  assign grid_x = GRID_BITS'(x_prod >> 16);
  assign grid_y = GRID_BITS'(y_prod >> 16);

  // The CD word pairs with the TIME_HIGH value held before this word.
  assign ts_full  = {time_high_reg, ts_lsb};
  assign ts_trunc = TS_BITS'(ts_full);
  assign entry    = {grid_x, grid_y, pol, ts_trunc};

  assign {out_x, out_y, out_pol, out_ts} = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      time_high_reg <= '0;
      ts_seen       <= 1'b0;
      evt_count     <= '0;
      drop_count    <= '0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      count_reg     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (accept && is_th) begin
        time_high_reg <= in_data[27:0];
        ts_seen       <= 1'b1;
      end
      if (push) begin
        fifo_mem[wr_ptr_reg] <= entry;
        wr_ptr_reg           <= ~wr_ptr_reg;
        if (evt_count != {CNT_BITS{1'b1}}) begin
          evt_count <= evt_count + 1'b1;
        end
      end
      if (drop && (drop_count != {CNT_BITS{1'b1}})) begin
        drop_count <= drop_count + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + 2'(push) - 2'(pop);
    end
  end

endmodule
